// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
//
// Generates the clock-enable for the single-cycle CPU's state update.
//   - Step mode: each fresh press of the debounced step button yields exactly
//     one CE pulse. The controller then waits in RELEASE for a holdoff period
//     and for the button to be let go before it re-arms.
//   - Run mode: CE is issued once every RUN_DIV cycles while the run switch
//     is on.
//   - Halt: a CPU halt forces the HALTED state. Only Clear_in, given while
//     halt is low, leaves HALTED.
//
// Parameters
//   RUN_DIV        CLK_in cycles per CE pulse in run mode (>=1)
//   HOLDOFF_CYCLES minimum RELEASE cycles after a step pulse (>=1)
//   COUNT_W        width of Step_count_out
//
// Ports
//   CLK_in          in   1        system clock, posedge
//   RST_n_in        in   1        asynchronous active-low reset
//   Step_btn_in     in   1        debounced step button level (1 = pressed)
//   Run_sw_in       in   1        run-mode switch (1 = free run)
//   Halt_in         in   1        CPU halt level
//   Clear_in        in   1        synchronous count clear; also exits HALTED
//   CPU_CE_out      out  1        registered one-cycle CPU clock enable
//   Step_count_out  out  COUNT_W  CE pulses issued, wraps modulo 2^COUNT_W
//   State_out       out  3        IDLE=0 PULSE=1 RELEASE=2 RUN=3 HALTED=4
// ---------------------------------------------------------------------------
module cpu_step_controller #(
  parameter int RUN_DIV        = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int COUNT_W        = 16
) (
  input  logic               CLK_in,
  input  logic               RST_n_in,
  input  logic               Step_btn_in,
  input  logic               Run_sw_in,
  input  logic               Halt_in,
  input  logic               Clear_in,
  output logic               CPU_CE_out,
  output logic [COUNT_W-1:0] Step_count_out,
  output logic [2:0]         State_out
);

  // Counter widths are held at 1 bit or more so that degenerate parameter
  // values (RUN_DIV=1, HOLDOFF_CYCLES=1) still elaborate.
  localparam int DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PULSE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   divider;
  logic [HOLD_W-1:0]  holdoff;
  logic               btn_q;
  logic               rise;
  logic [COUNT_W-1:0] step_count;

  // btn_q resets to 1. A button that is already held when reset releases
  // therefore has no rising edge and does not produce a step.
  assign rise = Step_btn_in & ~btn_q;

  assign State_out      = state;
  assign Step_count_out = step_count;

  // Main sequencer. CPU_CE_out is registered together with the state, so it
  // is high exactly in the PULSE cycle and in the RUN tick cycles. Halt
  // overrides every transition except leaving HALTED itself. A PULSE that has
  // already been entered keeps its CE, because that CE was registered on the
  // entry edge.
  always_ff @(posedge CLK_in or negedge RST_n_in) begin
    if (!RST_n_in) begin
      state      <= ST_IDLE;
      CPU_CE_out <= 1'b0;
      divider    <= '0;
      holdoff    <= '0;
      btn_q      <= 1'b1;
    end else begin
      btn_q      <= Step_btn_in;
      CPU_CE_out <= 1'b0;
      if (Halt_in && (state != ST_HALTED)) begin
        state   <= ST_HALTED;
        divider <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            // The run switch takes precedence over a simultaneous press.
            if (Run_sw_in) begin
              state   <= ST_RUN;
              divider <= '0;
            end else if (rise) begin
              state      <= ST_PULSE;
              CPU_CE_out <= 1'b1;
            end
          end

          ST_PULSE: begin
            state   <= ST_RELEASE;
            holdoff <= HOLD_INIT;
          end

          ST_RELEASE: begin
            // Presses here are dropped. Re-arming requires both the holdoff
            // to have expired and the button to be up.
            if (holdoff != '0) begin
              holdoff <= holdoff - HOLD_W'(1);
            end else if (!Step_btn_in) begin
              state <= ST_IDLE;
            end
          end

          ST_RUN: begin
            // A switch sampled low suppresses any tick that would have fired
            // on the same edge.
            if (!Run_sw_in) begin
              state   <= ST_IDLE;
              divider <= '0;
            end else if (divider == DIV_LAST) begin
              divider    <= '0;
              CPU_CE_out <= 1'b1;
            end else begin
              divider <= divider + DIV_W'(1);
            end
          end

          ST_HALTED: begin
            if (Clear_in && !Halt_in) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // The count increments at the end of each cycle in which CE is high. A
  // reset that lands during a CE cycle therefore leaves no partial count
  // behind. When Clear_in and an increment coincide, the clear wins.
  always_ff @(posedge CLK_in or negedge RST_n_in) begin
    if (!RST_n_in) begin
      step_count <= '0;
    end else if (Clear_in) begin
      step_count <= '0;
    end else if (CPU_CE_out) begin
      step_count <= step_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_controller
//
// Self-checking bench for cpu_step_controller. It uses RUN_DIV=4,
// HOLDOFF_CYCLES=8 and COUNT_W=4, so that counter wrap is reachable quickly.
//
// The reference model describes the behaviour in terms of elapsed time
// rather than hardware counters:
//   - RUN emits CE on every RUN_DIV-th cycle it has spent in RUN.
//   - RELEASE may exit once it has lasted HOLDOFF_CYCLES cycles and the
//     button is up.
//   - The count is an integer taken modulo 2^COUNT_W.
// ---------------------------------------------------------------------------
module tb_cpu_step_controller;

  localparam int RUN_DIV = 4;
  localparam int HOLD    = 8;
  localparam int CW      = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PULSE   = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  logic          CLK_in      = 1'b0;
  logic          RST_n_in    = 1'b0;
  logic          Step_btn_in = 1'b0;
  logic          Run_sw_in   = 1'b0;
  logic          Halt_in     = 1'b0;
  logic          Clear_in    = 1'b0;
  logic          CPU_CE_out;
  logic [CW-1:0] Step_count_out;
  logic [2:0]    State_out;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [2:0] m_state;
  logic       m_ce;
  int         m_count;
  logic       m_btn_q;
  int         run_age;
  int         rel_age;

  cpu_step_controller #(
    .RUN_DIV        (RUN_DIV),
    .HOLDOFF_CYCLES (HOLD),
    .COUNT_W        (CW)
  ) dut (
    .CLK_in         (CLK_in),
    .RST_n_in       (RST_n_in),
    .Step_btn_in    (Step_btn_in),
    .Run_sw_in      (Run_sw_in),
    .Halt_in        (Halt_in),
    .Clear_in       (Clear_in),
    .CPU_CE_out     (CPU_CE_out),
    .Step_count_out (Step_count_out),
    .State_out      (State_out)
  );

  always #5 CLK_in = ~CLK_in;

  task automatic model_reset();
    m_state = S_IDLE;
    m_ce    = 1'b0;
    m_count = 0;
    m_btn_q = 1'b1;
    run_age = 0;
    rel_age = 0;
  endtask

  // Advance one clock edge and update the model from the inputs sampled at
  // that edge. Returns 1 time unit after the edge, when outputs are stable.
  task automatic cycle();
    logic       rise;
    logic       nce;
    logic [2:0] nxt;
    @(posedge CLK_in);
    rise = Step_btn_in && !m_btn_q;
    if (Clear_in) m_count = 0;
    else if (m_ce) m_count = (m_count + 1) % (1 << CW);
    nce = 1'b0;
    nxt = m_state;
    if (Halt_in && m_state != S_HALTED) begin
      nxt = S_HALTED;
    end else begin
      case (m_state)
        S_IDLE:
          if (Run_sw_in) begin
            nxt = S_RUN;
            run_age = 0;
          end else if (rise) begin
            nxt = S_PULSE;
            nce = 1'b1;
          end
        S_PULSE: begin
          nxt = S_RELEASE;
          rel_age = 0;
        end
        S_RELEASE:
          if (rel_age >= HOLD - 1 && !Step_btn_in) nxt = S_IDLE;
          else rel_age++;
        S_RUN:
          if (!Run_sw_in) begin
            nxt = S_IDLE;
          end else begin
            run_age++;
            nce = ((run_age % RUN_DIV) == 0);
          end
        S_HALTED:
          if (Clear_in && !Halt_in) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
    m_state = nxt;
    m_ce    = nce;
    m_btn_q = Step_btn_in;
    #1;
  endtask

  task automatic apply_reset();
    RST_n_in = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge CLK_in);
    #1;
    RST_n_in = 1'b1;
  endtask

  // Return all inputs to idle levels and let any holdoff expire.
  task automatic settle();
    Step_btn_in = 1'b0;
    Run_sw_in   = 1'b0;
    Halt_in     = 1'b0;
    Clear_in    = 1'b0;
    repeat (HOLD + 4) cycle();
  endtask

  task automatic test_reset();
    int n_ce;
    Step_btn_in = 1'b1;
    apply_reset();
    total++; if (State_out !== S_IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d expected %0d", State_out, S_IDLE); end
    total++; if (CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_ce: got %0b expected 0", CPU_CE_out); end
    total++; if (Step_count_out !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", Step_count_out); end
    n_ce = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (CPU_CE_out === 1'b1) n_ce++;
    end
    total++; if (n_ce != 0) begin bad++; $display("[TB] FAIL held_btn_ce: got %0d pulses expected 0", n_ce); end
    total++; if (Step_count_out !== '0) begin bad++; $display("[TB] FAIL held_btn_count: got %0d expected 0", Step_count_out); end
    Step_btn_in = 1'b0;
    cycle();
    Step_btn_in = 1'b1;
    cycle();
    total++; if (CPU_CE_out !== 1'b1 || State_out !== S_PULSE) begin bad++; $display("[TB] FAIL press_pulse: got ce=%0b st=%0d expected ce=1 st=1", CPU_CE_out, State_out); end
    cycle();
    total++; if (CPU_CE_out !== 1'b0 || State_out !== S_RELEASE) begin bad++; $display("[TB] FAIL pulse_width: got ce=%0b st=%0d expected ce=0 st=2", CPU_CE_out, State_out); end
    total++; if (Step_count_out !== CW'(1)) begin bad++; $display("[TB] FAIL step_count1: got %0d expected 1", Step_count_out); end
  endtask

  task automatic test_holdoff();
    int n_ce;
    settle();
    Clear_in = 1'b1;
    cycle();
    Clear_in = 1'b0;
    total++; if (Step_count_out !== '0 || State_out !== S_IDLE) begin bad++; $display("[TB] FAIL holdoff_pre: got cnt=%0d st=%0d expected cnt=0 st=0", Step_count_out, State_out); end
    n_ce = 0;
    for (int i = 0; i < 12; i++) begin
      Step_btn_in = (i == 0 || i == 3);
      cycle();
      if (CPU_CE_out === 1'b1) n_ce++;
      total++; if (CPU_CE_out !== m_ce || State_out !== m_state) begin bad++; $display("[TB] FAIL holdoff_cycle%0d: got ce=%0b st=%0d expected ce=%0b st=%0d", i, CPU_CE_out, State_out, m_ce, m_state); end
    end
    total++; if (n_ce != 1) begin bad++; $display("[TB] FAIL holdoff_pulses: got %0d expected 1", n_ce); end
    total++; if (State_out !== S_IDLE) begin bad++; $display("[TB] FAIL holdoff_rearm: got st=%0d expected 0", State_out); end
    Step_btn_in = 1'b1;
    cycle();
    total++; if (CPU_CE_out !== 1'b1) begin bad++; $display("[TB] FAIL second_press: got ce=%0b expected 1", CPU_CE_out); end
    Step_btn_in = 1'b0;
    cycle();
    total++; if (Step_count_out !== CW'(2)) begin bad++; $display("[TB] FAIL step_count2: got %0d expected 2", Step_count_out); end
  endtask

  task automatic test_run();
    logic exp_ce;
    settle();
    Clear_in = 1'b1;
    cycle();
    Clear_in  = 1'b0;
    Run_sw_in = 1'b1;
    cycle();
    total++; if (State_out !== S_RUN || CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL run_entry: got st=%0d ce=%0b expected st=3 ce=0", State_out, CPU_CE_out); end
    for (int i = 1; i <= 20; i++) begin
      cycle();
      exp_ce = ((i % 4) == 0);
      total++; if (CPU_CE_out !== exp_ce || CPU_CE_out !== m_ce) begin bad++; $display("[TB] FAIL run_tick%0d: got ce=%0b expected %0b", i, CPU_CE_out, exp_ce); end
    end
    Run_sw_in = 1'b0;
    cycle();
    total++; if (State_out !== S_IDLE || CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL run_exit: got st=%0d ce=%0b expected st=0 ce=0", State_out, CPU_CE_out); end
    total++; if (Step_count_out !== CW'(5)) begin bad++; $display("[TB] FAIL run_count: got %0d expected 5", Step_count_out); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      total++; if (CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL run_after%0d: got ce=%0b expected 0", i, CPU_CE_out); end
    end
  endtask

  task automatic test_halt();
    settle();
    Clear_in = 1'b1;
    cycle();
    Clear_in  = 1'b0;
    Run_sw_in = 1'b1;
    cycle();
    repeat (6) cycle();
    Halt_in = 1'b1;
    cycle();
    Halt_in = 1'b0;
    total++; if (State_out !== S_HALTED || CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL halt_enter: got st=%0d ce=%0b expected st=4 ce=0", State_out, CPU_CE_out); end
    total++; if (Step_count_out !== CW'(1)) begin bad++; $display("[TB] FAIL halt_count: got %0d expected 1", Step_count_out); end
    Run_sw_in = 1'b0;
    cycle();
    total++; if (State_out !== S_HALTED) begin bad++; $display("[TB] FAIL halt_stay: got st=%0d expected 4", State_out); end
    Clear_in = 1'b1;
    Halt_in  = 1'b1;
    cycle();
    total++; if (State_out !== S_HALTED || Step_count_out !== '0) begin bad++; $display("[TB] FAIL clear_with_halt: got st=%0d cnt=%0d expected st=4 cnt=0", State_out, Step_count_out); end
    Halt_in = 1'b0;
    cycle();
    Clear_in = 1'b0;
    total++; if (State_out !== S_IDLE || Step_count_out !== '0) begin bad++; $display("[TB] FAIL halt_exit: got st=%0d cnt=%0d expected st=0 cnt=0", State_out, Step_count_out); end
  endtask

  task automatic test_wrap();
    settle();
    Clear_in = 1'b1;
    cycle();
    Clear_in  = 1'b0;
    Run_sw_in = 1'b1;
    cycle();
    for (int i = 1; i <= 68; i++) begin
      cycle();
      total++; if (Step_count_out !== CW'(m_count)) begin bad++; $display("[TB] FAIL wrap_model%0d: got %0d expected %0d", i, Step_count_out, m_count); end
      if (i == 61) begin
        total++; if (Step_count_out !== CW'(15)) begin bad++; $display("[TB] FAIL wrap_pre: got %0d expected 15", Step_count_out); end
      end
      if (i == 65) begin
        total++; if (Step_count_out !== '0) begin bad++; $display("[TB] FAIL wrap_zero: got %0d expected 0", Step_count_out); end
      end
    end
    total++; if (CPU_CE_out !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ce68: got ce=%0b expected 1", CPU_CE_out); end
    Clear_in = 1'b1;
    cycle();
    Clear_in = 1'b0;
    total++; if (Step_count_out !== '0 || State_out !== S_RUN) begin bad++; $display("[TB] FAIL clear_vs_inc: got cnt=%0d st=%0d expected cnt=0 st=3", Step_count_out, State_out); end
    Run_sw_in = 1'b0;
    cycle();
  endtask

  task automatic test_async_reset();
    settle();
    Clear_in = 1'b1;
    cycle();
    Clear_in  = 1'b0;
    Run_sw_in = 1'b1;
    cycle();
    repeat (8) cycle();
    total++; if (CPU_CE_out !== 1'b1 || Step_count_out !== CW'(1)) begin bad++; $display("[TB] FAIL areset_pre: got ce=%0b cnt=%0d expected ce=1 cnt=1", CPU_CE_out, Step_count_out); end
    #2;
    RST_n_in = 1'b0;
    #1;
    model_reset();
    total++; if (CPU_CE_out !== 1'b0) begin bad++; $display("[TB] FAIL areset_ce: got %0b expected 0", CPU_CE_out); end
    total++; if (Step_count_out !== '0) begin bad++; $display("[TB] FAIL areset_count: got %0d expected 0", Step_count_out); end
    total++; if (State_out !== S_IDLE) begin bad++; $display("[TB] FAIL areset_state: got %0d expected 0", State_out); end
    Run_sw_in = 1'b0;
    @(posedge CLK_in);
    #1;
    RST_n_in = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) Step_btn_in = ~Step_btn_in;
      if ($urandom_range(39) == 0) Run_sw_in = ~Run_sw_in;
      Halt_in  = ($urandom_range(49) == 0);
      Clear_in = ($urandom_range(29) == 0);
      cycle();
      total++; if (CPU_CE_out !== m_ce || State_out !== m_state || Step_count_out !== CW'(m_count)) begin
        bad++;
        $display("[TB] FAIL random%0d: got ce=%0b st=%0d cnt=%0d expected ce=%0b st=%0d cnt=%0d", i, CPU_CE_out, State_out, Step_count_out, m_ce, m_state, m_count);
      end
    end
    Halt_in  = 1'b0;
    Clear_in = 1'b1;
    cycle();
    Clear_in = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_holdoff();
    test_run();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
